irq_request_reg: RTL

- Parametrised, clocked Interrupt Request Register for the 8259-style PIC. Successor to the combinational 8-bit IRR.
- Synchronises NUM_IRQ raw request lines and supports per-mode edge or level triggering. Supports a freeze window during the INTA sequence and per-bit clear on acknowledge.
- Feeds the priority resolver and ISR logic. Also provides a fixed-priority pending summary for the control FSM.

---
 rtl/pic_pkg.sv | 11 +
 rtl/irq_sync.sv | 30 +++
 rtl/irq_request_reg.sv | 89 ++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared PIC constants: default channel/synchroniser sizing and the ICW1 LTIM
// trigger-mode encodings also used by the control-word decoder.
package pic_pkg;

    localparam int PIC_NUM_IRQ     = 8;
    localparam int PIC_SYNC_STAGES = 2;

    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Single-line multi-flop synchroniser bringing an asynchronous IR line into
// the clk domain; q is the last stage.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) chain <= '0;
                else     chain <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) chain <= '0;
                else     chain <= {chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_request_reg.sv
// Clocked 8259-style Interrupt Request Register: synchronised IR lines, edge or
// level triggering, INTA freeze window, per-bit acknowledge clear, priority summary.
module irq_request_reg
    import pic_pkg::*;
#(
    parameter int NUM_IRQ     = PIC_NUM_IRQ,
    parameter int SYNC_STAGES = PIC_SYNC_STAGES,
    parameter int IDX_W       = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] interrupt_requests,
    input  logic               ltim,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_irr,
    output logic [NUM_IRQ-1:0] irr_out,
    output logic               irr_any,
    output logic [IDX_W-1:0]   irr_highest
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic [NUM_IRQ-1:0]  sync;
    logic [NUM_IRQ-1:0]  arm;
    logic [NUM_IRQ-1:0]  arm_next;
    logic [NUM_IRQ-1:0]  irr_next;
    logic [NUM_IRQ-1:0]  set_vec;
    logic                ltim_q;
    logic                mode_change;
    logic [SETTLE_W-1:0] settle;
    logic                primed;

    generate
        for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
            irq_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (interrupt_requests[g]),
                .q   (sync[g])
            );
        end
    endgenerate

    // The synchroniser outputs still hold reset zeros for SYNC_STAGES cycles after
    // release; arming on them would turn a line held high through reset into an edge.
    assign primed      = (settle == SETTLE_W'(SYNC_STAGES));
    assign mode_change = (ltim != ltim_q);
    assign set_vec     = {NUM_IRQ{~freeze}} & sync & arm;

    always_comb begin
        arm_next = arm;
        irr_next = irr_out;
        if (mode_change) begin
            arm_next = '0;
        end else if (ltim == TRIG_LEVEL) begin
            arm_next = '0;
            irr_next = freeze ? (irr_out & ~clear_irr) : (sync & ~clear_irr);
        end else begin
            arm_next = primed ? ((arm & ~set_vec) | ~sync) : '0;
            irr_next = (irr_out | set_vec) & ~clear_irr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irr_out <= '0;
            arm     <= '0;
            ltim_q  <= TRIG_EDGE;
            settle  <= '0;
        end else begin
            irr_out <= irr_next;
            arm     <= arm_next;
            ltim_q  <= ltim;
            if (!primed) settle <= settle + SETTLE_W'(1);
        end
    end

    assign irr_any = |irr_out;

    always_comb begin
        irr_highest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irr_out[i]) irr_highest = IDX_W'(i);
        end
    end

endmodule
